// File: rtl/xoodoo_permute.sv
// Iterative Xoodoo[n_r] permutation core.
//
// Loads a 384-bit state on an accepted start, applies NROUNDS rounds (one per
// clock, or two per clock when XOODOO_UNROLL2_EN is defined), then pulses done
// for one cycle with the result on state_o. The result is held until the next
// accepted start or reset.
//
// Ports:
//   clk_i    rising-edge clock
//   reset_i  asynchronous active-high reset
//   start_i  single-cycle request, accepted only while idle
//   state_i  state to permute, sampled on an accepted start
//   state_o  working/result state (valid while done_o=1 and held afterwards)
//   done_o   one-cycle completion pulse
//   busy_o   high while rounds are being applied
//
// Configuration macro: XOODOO_UNROLL2_EN (two cascaded rounds per cycle,
// NROUNDS must be even).
module xoodoo_permute #(
  parameter int unsigned NROUNDS = 12
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [383:0] state_i,
  output logic [383:0] state_o,
  output logic         done_o,
  output logic         busy_o
);

`ifdef XOODOO_UNROLL2_EN
  localparam int unsigned RoundsPerCycle = 2;
`else
  localparam int unsigned RoundsPerCycle = 1;
`endif

  // Rounds use the tail of the 12-entry constant table.
  localparam logic [3:0] FirstIdx = 4'(12 - NROUNDS);
  // rc value seen on the edge that applies the final round(s).
  localparam logic [3:0] LastRc   = 4'(NROUNDS - RoundsPerCycle);
  localparam logic [3:0] RcStep   = 4'(RoundsPerCycle);

  if (NROUNDS < 1 || NROUNDS > 12) begin : g_bad_rounds
    $error("xoodoo_permute: NROUNDS must be in 1..12");
  end
`ifdef XOODOO_UNROLL2_EN
  if (NROUNDS % 2 != 0) begin : g_odd_rounds
    $error("xoodoo_permute: NROUNDS must be even with two rounds per cycle");
  end
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e       st_q, st_d;
  logic [3:0]   rc_q, rc_d;
  logic [383:0] state_q, state_d;
  logic [383:0] round_out;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    // n=0 shifts right by 32, which yields zero, so the result is v.
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] round_const(input logic [3:0] idx);
    logic [31:0] c;
    c = '0;
    case (idx)
      4'd0:  c = 32'h058;
      4'd1:  c = 32'h038;
      4'd2:  c = 32'h3C0;
      4'd3:  c = 32'h0D0;
      4'd4:  c = 32'h120;
      4'd5:  c = 32'h014;
      4'd6:  c = 32'h060;
      4'd7:  c = 32'h02C;
      4'd8:  c = 32'h380;
      4'd9:  c = 32'h0F0;
      4'd10: c = 32'h1A0;
      4'd11: c = 32'h012;
      default: c = '0;
    endcase
    return c;
  endfunction

  // One Xoodoo round. Lane (x,y) lives at index 4*y+x of a[]/t[].
  function automatic logic [383:0] xoodoo_round(input logic [383:0] s, input logic [31:0] c);
    logic [31:0]  a [12];
    logic [31:0]  t [12];
    logic [31:0]  p [4];
    logic [31:0]  e [4];
    logic [383:0] r;
    for (int i = 0; i < 12; i++) a[i] = s[32*i +: 32];
    // theta
    for (int x = 0; x < 4; x++) p[x] = a[x] ^ a[4+x] ^ a[8+x];
    for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
    for (int i = 0; i < 12; i++) a[i] = a[i] ^ e[i%4];
    // rho-west
    for (int x = 0; x < 4; x++) begin
      t[x]   = a[x];
      t[4+x] = a[4+(x+3)%4];
      t[8+x] = rotl(a[8+x], 11);
    end
    // iota
    t[0] = t[0] ^ c;
    // chi, all terms taken from the pre-chi planes in t[]
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        a[4*y+x] = t[4*y+x] ^ (~t[4*((y+1)%3)+x] & t[4*((y+2)%3)+x]);
      end
    end
    // rho-east
    for (int x = 0; x < 4; x++) begin
      t[x]   = a[x];
      t[4+x] = rotl(a[4+x], 1);
      t[8+x] = rotl(a[8+(x+2)%4], 8);
    end
    for (int i = 0; i < 12; i++) r[32*i +: 32] = t[i];
    return r;
  endfunction

`ifdef XOODOO_UNROLL2_EN
  logic [383:0] round_mid;
  always_comb begin
    round_mid = xoodoo_round(state_q, round_const(FirstIdx + rc_q));
    round_out = xoodoo_round(round_mid, round_const(FirstIdx + rc_q + 4'd1));
  end
`else
  always_comb begin
    round_out = xoodoo_round(state_q, round_const(FirstIdx + rc_q));
  end
`endif

  always_comb begin
    st_d    = st_q;
    rc_d    = rc_q;
    state_d = state_q;
    unique case (st_q)
      StIdle: begin
        if (start_i) begin
          state_d = state_i;
          rc_d    = '0;
          st_d    = StRun;
        end
      end
      StRun: begin
        state_d = round_out;
        rc_d    = rc_q + RcStep;
        if (rc_q == LastRc) st_d = StDone;
      end
      StDone: begin
        st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      st_q    <= StIdle;
      rc_q    <= '0;
      state_q <= '0;
    end else begin
      st_q    <= st_d;
      rc_q    <= rc_d;
      state_q <= state_d;
    end
  end

  // Outputs decode registered state only.
  assign state_o = state_q;
  assign done_o  = (st_q == StDone);
  assign busy_o  = (st_q == StRun);

endmodule

// File: tb/tb_xoodoo_permute.sv
module tb_xoodoo_permute;

`ifdef XOODOO_UNROLL2_EN
  localparam int NrSmall  = 2;
  localparam int LatSmall = 1;
  localparam int Lat12    = 6;
`else
  localparam int NrSmall  = 1;
  localparam int LatSmall = 1;
  localparam int Lat12    = 12;
`endif

  localparam logic [31:0] RcTab [12] = '{
    32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
    32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
  };

  logic         clk = 1'b0;
  logic         reset;
  logic         start12, start_s;
  logic [383:0] st_in;
  logic [383:0] out12, outs;
  logic         done12, busy12, dones, busys;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xoodoo_permute #(.NROUNDS(12)) u_dut12 (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start12),
    .state_i (st_in),
    .state_o (out12),
    .done_o  (done12),
    .busy_o  (busy12)
  );

  xoodoo_permute #(.NROUNDS(NrSmall)) u_dut_s (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start_s),
    .state_i (st_in),
    .state_o (outs),
    .done_o  (dones),
    .busy_o  (busys)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (n == 0) ? v : ((v << n) | (v >> (32 - n)));
  endfunction

  // Plane shift: B[x] = A[(x-t) mod 4] rotated left by v.
  function automatic logic [3:0][31:0] pshift(input logic [3:0][31:0] p, input int t,
                                              input int v);
    logic [3:0][31:0] b;
    for (int x = 0; x < 4; x++) b[x] = rol(p[(x - t + 4) % 4], v);
    return b;
  endfunction

  function automatic logic [383:0] model(input logic [383:0] s, input int nr);
    logic [2:0][3:0][31:0] a;
    logic [3:0][31:0]      p, e, b0, b1, b2;
    a = s;
    for (int r = 12 - nr; r < 12; r++) begin
      p = a[0] ^ a[1] ^ a[2];
      e = pshift(p, 1, 5) ^ pshift(p, 1, 14);
      for (int y = 0; y < 3; y++) a[y] = a[y] ^ e;
      a[1] = pshift(a[1], 1, 0);
      a[2] = pshift(a[2], 0, 11);
      a[0][0] = a[0][0] ^ RcTab[r];
      b0 = ~a[1] & a[2];
      b1 = ~a[2] & a[0];
      b2 = ~a[0] & a[1];
      a[0] = a[0] ^ b0;
      a[1] = a[1] ^ b1;
      a[2] = a[2] ^ b2;
      a[1] = pshift(a[1], 0, 1);
      a[2] = pshift(a[2], 2, 8);
    end
    return a;
  endfunction

  function automatic logic [383:0] rand384();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full run on the 12-round core. poke_at >= 0 re-pulses start (with a
  // different state) in the cycle where rc equals poke_at. A start is also
  // pulsed in the done cycle, which must be ignored.
  task automatic do_run(input string tag, input logic [383:0] s, input int poke_at,
                        output logic [383:0] res);
    int lat;
    int bcnt;
    logic [383:0] exp;
    exp  = model(s, 12);
    lat  = -1;
    bcnt = 0;
    st_in   = s;
    start12 = 1'b1;
    tick();
    start12 = 1'b0;
    st_in   = rand384();
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      if (busy12) bcnt++;
      if (n - 1 == poke_at) begin
        start12 = 1'b1;
        st_in   = rand384();
      end
      tick();
      start12 = 1'b0;
      if (done12) lat = n;
    end
    chk({tag, "_latency"}, 384'(lat), 384'(Lat12));
    chk({tag, "_busy_cycles"}, 384'(bcnt), 384'(Lat12));
    chk({tag, "_result"}, out12, exp);
    chk({tag, "_busy_at_done"}, 384'(busy12), 384'(0));
    res = out12;
    // start during the done cycle
    start12 = 1'b1;
    st_in   = rand384();
    tick();
    start12 = 1'b0;
    chk({tag, "_done_single"}, 384'(done12), 384'(0));
    chk({tag, "_held"}, out12, exp);
    tick();
    chk({tag, "_not_restarted"}, 384'(busy12), 384'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [383:0] r0, r1, rs, exp_s;
    int lat_s;
    int dcnt;
    reset   = 1'b1;
    start12 = 1'b0;
    start_s = 1'b0;
    st_in   = '0;
    tick();
    tick();
    chk("rst_state", out12, '0);
    chk("rst_done", 384'(done12), 384'(0));
    chk("rst_busy", 384'(busy12), 384'(0));
    reset = 1'b0;
    tick();
    chk("idle_state", out12, '0);
    chk("idle_busy", 384'(busy12), 384'(0));
    chk("idle_small_state", outs, '0);

    // Minimal round count on zero state
    st_in   = '0;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    chk("small_busy", 384'(busys), 384'(1));
    lat_s = -1;
    for (int n = 1; n <= 20 && lat_s < 0; n++) begin
      tick();
      if (dones) lat_s = n;
    end
    chk("small_latency", 384'(lat_s), 384'(LatSmall));
`ifdef XOODOO_UNROLL2_EN
    exp_s = model('0, NrSmall);
`else
    exp_s = '0;
    exp_s[31:0]    = 32'h00000012;
    exp_s[159:128] = 32'h00000024;
`endif
    chk("small_fixed", outs, exp_s);
    chk("small_model", outs, model('0, NrSmall));

    // Full round count
    do_run("zero", '0, -1, r0);
    do_run("b2b", r0, -1, r1);
    chk("b2b_twice", r1, model(model('0, 12), 12));
    for (int i = 0; i < 3; i++) begin
      do_run("rand", rand384(), -1, rs);
    end
    do_run("poke_rc5", rand384(), 5, rs);

    // Reset mid-run at rc=7
    st_in   = rand384();
    start12 = 1'b1;
    tick();
    start12 = 1'b0;
    for (int n = 0; n < 7; n++) tick();
    chk("mid_busy_before_rst", 384'(busy12), 384'(1));
    reset = 1'b1;
    #1;
    chk("mid_rst_state", out12, '0);
    chk("mid_rst_busy", 384'(busy12), 384'(0));
    chk("mid_rst_done", 384'(done12), 384'(0));
    tick();
    reset = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (done12 || busy12) dcnt++;
    end
    chk("post_rst_quiet", 384'(dcnt), 384'(0));
    do_run("after_rst", rand384(), -1, rs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
